// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, transaction owner and grant bit positions.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    Idle  = 2'd0,
    Issue = 2'd1,
    Resp  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OwnerIf = 1'b0,
    OwnerLs = 1'b1
  } arb_owner_e;

  localparam int unsigned GrantIf = 0;
  localparam int unsigned GrantLs = 1;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner picker for the fetch/LSU ports; one-hot grant, gated by accept_en.
// MEM_ARB_RR_EN: alternate on ties using a one-bit last-grant pointer; otherwise LSU always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic       clk_i,
  input  logic       rst_i,
`endif
  input  logic       if_valid,
  input  logic       ls_valid,
  input  logic       accept_en,
  output logic [1:0] grant
);

  logic ls_wins;

`ifdef MEM_ARB_RR_EN
  // Pointer remembers whether the LSU got the last grant; reset means "fetch last".
  logic last_ls_q;

  always_comb ls_wins = ls_valid && (!if_valid || !last_ls_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_ls_q <= 1'b0;
    end else if (accept_en && (if_valid || ls_valid)) begin
      last_ls_q <= ls_wins;
    end
  end
`else
  always_comb ls_wins = ls_valid;
`endif

  always_comb begin
    grant = '0;
    if (accept_en) begin
      grant[GrantLs] = ls_wins;
      grant[GrantIf] = if_valid && !ls_wins;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and the LSU, one transaction in flight.
// Build option MEM_ARB_RR_EN selects round-robin tie breaking in the picker.
//
// state | meaning
// Idle  | no transaction; accept a new request
// Issue | mem_valid_o high with latched payload until mem_ready_i
// Resp  | waiting for mem_rvalid_i; route it to owner and re-arbitrate
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   if_valid_i,
  output logic                   if_ready_o,
  input  logic [AddrWidth-1:0]   if_addr_i,
  output logic [DataWidth-1:0]   if_rdata_o,
  output logic                   if_rvalid_o,
  input  logic                   ls_valid_i,
  output logic                   ls_ready_o,
  input  logic [AddrWidth-1:0]   ls_addr_i,
  input  logic [DataWidth-1:0]   ls_wdata_i,
  input  logic [DataWidth/8-1:0] ls_wmask_i,
  output logic [DataWidth-1:0]   ls_rdata_o,
  output logic                   ls_rvalid_o,
  output logic                   mem_valid_o,
  input  logic                   mem_ready_i,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  output logic [DataWidth/8-1:0] mem_wmask_o,
  input  logic [DataWidth-1:0]   mem_rdata_i,
  input  logic                   mem_rvalid_i
);

  arb_state_e             state_q, state_d;
  arb_owner_e             owner_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [DataWidth/8-1:0] wmask_q;
  logic [1:0]             grant;
  logic                   accept_en;
  logic                   resp;
  logic                   take;

  always_comb begin
    resp      = (state_q == Resp) && mem_rvalid_i;
    accept_en = (state_q == Idle) || resp;
  end

  mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .clk_i     (clk_i),
    .rst_i     (rst_i),
`endif
    .if_valid  (if_valid_i),
    .ls_valid  (ls_valid_i),
    .accept_en (accept_en),
    .grant     (grant)
  );

  always_comb begin
    take        = |grant;
    if_ready_o  = grant[GrantIf];
    ls_ready_o  = grant[GrantLs];
    if_rvalid_o = resp && (owner_q == OwnerIf);
    ls_rvalid_o = resp && (owner_q == OwnerLs);
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    ls_rdata_o  = ls_rvalid_o ? mem_rdata_i : '0;
    mem_valid_o = (state_q == Issue);
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    mem_wmask_o = wmask_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Idle:    if (take) state_d = Issue;
      Issue:   if (mem_ready_i) state_d = Resp;
      Resp:    if (mem_rvalid_i) state_d = take ? Issue : Idle;
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= Idle;
      owner_q <= OwnerIf;
    end else begin
      state_q <= state_d;
      if (take) owner_q <= grant[GrantLs] ? OwnerLs : OwnerIf;
    end
  end

  // Payload is only observed while in Issue, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (take) begin
      addr_q  <= grant[GrantLs] ? ls_addr_i : if_addr_i;
      wdata_q <= grant[GrantLs] ? ls_wdata_i : '0;
      wmask_q <= grant[GrantLs] ? ls_wmask_i : '0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_valid_i, if_ready_o, if_rvalid_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        ls_valid_i, ls_ready_o, ls_rvalid_o;
  logic [31:0] ls_addr_i, ls_wdata_i, ls_rdata_o;
  logic [3:0]  ls_wmask_i;
  logic        mem_valid_o, mem_ready_i, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_wmask_o;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.AddrWidth(32), .DataWidth(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_valid_i(if_valid_i), .if_ready_o(if_ready_o), .if_addr_i(if_addr_i),
    .if_rdata_o(if_rdata_o), .if_rvalid_o(if_rvalid_o),
    .ls_valid_i(ls_valid_i), .ls_ready_o(ls_ready_o), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_wmask_i(ls_wmask_i),
    .ls_rdata_o(ls_rdata_o), .ls_rvalid_o(ls_rvalid_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: the single outstanding transaction, if any.
  bit          m_busy, m_issued, m_own_ls;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wmask;
  bit          m_last_ls;
  bit          e_if_ready, e_ls_ready;

  // DUT outputs sampled at the falling edge of the last cycle.
  logic        o_if_ready, o_ls_ready, o_if_rvalid, o_ls_rvalid, o_mem_valid;
  logic [31:0] o_if_rdata, o_ls_rdata, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_wmask;

  bit chk = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_issued = 0; m_own_ls = 0; m_last_ls = 0;
  endtask

  // One clock cycle: inputs are already driven (just after the rising edge).
  task automatic cycle();
    bit can_acc, resp, prefer_ls, win_ls, win_if;
    bit n_busy, n_issued, n_own_ls;
    logic [31:0] n_addr, n_wdata;
    logic [3:0]  n_wmask;
    #4;
    o_if_ready = if_ready_o;   o_ls_ready = ls_ready_o;
    o_if_rvalid = if_rvalid_o; o_ls_rvalid = ls_rvalid_o;
    o_if_rdata = if_rdata_o;   o_ls_rdata = ls_rdata_o;
    o_mem_valid = mem_valid_o; o_mem_addr = mem_addr_o;
    o_mem_wdata = mem_wdata_o; o_mem_wmask = mem_wmask_o;

    resp    = m_busy && m_issued && mem_rvalid_i;
    can_acc = !m_busy || resp;
`ifdef MEM_ARB_RR_EN
    prefer_ls = !m_last_ls;
`else
    prefer_ls = 1'b1;
`endif
    win_ls = can_acc && ls_valid_i && (!if_valid_i || prefer_ls);
    win_if = can_acc && if_valid_i && !win_ls;
    e_if_ready = win_if;
    e_ls_ready = win_ls;

    if (chk) begin
      check("if_ready", o_if_ready, 32'(win_if));
      check("ls_ready", o_ls_ready, 32'(win_ls));
      check("if_rvalid", o_if_rvalid, 32'(resp && !m_own_ls));
      check("ls_rvalid", o_ls_rvalid, 32'(resp && m_own_ls));
      check("if_rdata", o_if_rdata, (resp && !m_own_ls) ? mem_rdata_i : 32'h0);
      check("ls_rdata", o_ls_rdata, (resp && m_own_ls) ? mem_rdata_i : 32'h0);
      check("mem_valid", o_mem_valid, 32'(m_busy && !m_issued));
      if (m_busy && !m_issued) begin
        check("mem_addr", o_mem_addr, m_addr);
        check("mem_wdata", o_mem_wdata, m_wdata);
        check("mem_wmask", o_mem_wmask, 32'(m_wmask));
      end
    end

    n_busy = m_busy; n_issued = m_issued; n_own_ls = m_own_ls;
    n_addr = m_addr; n_wdata = m_wdata; n_wmask = m_wmask;
    if (m_busy && !m_issued && mem_ready_i) n_issued = 1;
    if (resp) n_busy = 0;
    if (win_ls || win_if) begin
      n_busy = 1; n_issued = 0; n_own_ls = win_ls;
      n_addr  = win_ls ? ls_addr_i : if_addr_i;
      n_wdata = win_ls ? ls_wdata_i : 32'h0;
      n_wmask = win_ls ? ls_wmask_i : 4'h0;
    end

    @(posedge clk_i);
    #1;
    if (rst_i) begin
      model_reset();
    end else begin
      if (win_ls || win_if) m_last_ls = win_ls;
      m_busy = n_busy; m_issued = n_issued; m_own_ls = n_own_ls;
      m_addr = n_addr; m_wdata = n_wdata; m_wmask = n_wmask;
    end
    chk = 1'b1;
  endtask

  task automatic idle_inputs();
    rst_i = 0; if_valid_i = 0; if_addr_i = 0; ls_valid_i = 0; ls_addr_i = 0;
    ls_wdata_i = 0; ls_wmask_i = 0; mem_ready_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
  endtask

  bit          if_pend, ls_pend;
  logic [31:0] addr_hold;

  initial begin
    idle_inputs();
    rst_i = 1;
    model_reset();
    cycle();                       // reset cycle, DUT state unknown beforehand
    rst_i = 0;

    // Reset values
    cycle();
    check("rst_mem_valid", o_mem_valid, 0);
    check("rst_if_rdata", o_if_rdata, 0);

    // Fetch-only read
    if_valid_i = 1; if_addr_i = 32'h100;
    cycle();
    check("f_if_ready_c0", o_if_ready, 1);
    if_valid_i = 0; if_addr_i = 0; mem_ready_i = 1;
    cycle();
    check("f_mem_valid_c1", o_mem_valid, 1);
    check("f_mem_addr_c1", o_mem_addr, 32'h100);
    check("f_mem_wmask_c1", o_mem_wmask, 0);
    mem_ready_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
    cycle();
    check("f_if_rvalid_c2", o_if_rvalid, 1);
    check("f_if_rdata_c2", o_if_rdata, 32'hDEADBEEF);
    check("f_ls_rdata_c2", o_ls_rdata, 0);
    idle_inputs();

    // Simultaneous requests, then a second tie at the LSU response
    if_valid_i = 1; if_addr_i = 32'h180;
    ls_valid_i = 1; ls_addr_i = 32'h200; ls_wdata_i = 32'h0000ABCD; ls_wmask_i = 4'h3;
    cycle();
    check("tie1_ls_ready", o_ls_ready, 1);
    check("tie1_if_ready", o_if_ready, 0);
    ls_addr_i = 32'h204; ls_wdata_i = 0; ls_wmask_i = 0; mem_ready_i = 1;
    cycle();
    check("tie1_mem_wdata", o_mem_wdata, 32'h0000ABCD);
    check("tie1_mem_wmask", o_mem_wmask, 32'h3);
    mem_ready_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h11;
    cycle();
    check("tie2_ls_rvalid", o_ls_rvalid, 1);
`ifdef MEM_ARB_RR_EN
    check("tie2_if_ready", o_if_ready, 1);
    if_valid_i = 0;
`else
    check("tie2_ls_ready", o_ls_ready, 1);
    ls_valid_i = 0;
`endif
    mem_rvalid_i = 0; mem_ready_i = 1;
    cycle();
    mem_ready_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h22;
    cycle();
    if_valid_i = 0; ls_valid_i = 0; mem_rvalid_i = 0; mem_ready_i = 1;
    cycle();
    mem_ready_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h33;
    cycle();
    idle_inputs();

    // Memory stall for 5 cycles
    if_valid_i = 1; if_addr_i = 32'h300;
    cycle();
    if_valid_i = 0;
    for (int i = 0; i < 5; i++) begin
      mem_rvalid_i = (i == 2);     // stray response while issuing
      cycle();
      check("stall_mem_valid", o_mem_valid, 1);
      check("stall_mem_addr", o_mem_addr, 32'h300);
      check("stall_no_ready", o_if_ready, 0);
    end
    mem_rvalid_i = 0; mem_ready_i = 1;
    cycle();
    check("stall_mem_valid_c6", o_mem_valid, 1);
    mem_ready_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h44;
    cycle();
    idle_inputs();

    // Stray response in Idle
    mem_rvalid_i = 1; mem_rdata_i = 32'h55;
    cycle();
    check("stray_if_rvalid", o_if_rvalid, 0);
    check("stray_ls_rvalid", o_ls_rvalid, 0);
    idle_inputs();

    // Reset during Resp, then a fresh fetch
    ls_valid_i = 1; ls_addr_i = 32'h400;
    cycle();
    ls_valid_i = 0; mem_ready_i = 1;
    cycle();
    mem_ready_i = 0; rst_i = 1;
    cycle();
    rst_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h66;
    cycle();
    check("rst_resp_mem_valid", o_mem_valid, 0);
    check("rst_resp_ls_rvalid", o_ls_rvalid, 0);
    mem_rvalid_i = 0; if_valid_i = 1; if_addr_i = 32'h500;
    cycle();
    check("post_rst_if_ready", o_if_ready, 1);
    if_valid_i = 0; mem_ready_i = 1;
    cycle();
    mem_ready_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h77;
    cycle();
    check("post_rst_if_rdata", o_if_rdata, 32'h77);
    idle_inputs();

    // Random traffic
    if_pend = 0; ls_pend = 0;
    for (int n = 0; n < 600; n++) begin
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1; if_addr_i = $urandom;
      end
      if (!ls_pend && $urandom_range(0, 2) == 0) begin
        ls_pend = 1; ls_addr_i = $urandom; ls_wdata_i = $urandom;
        ls_wmask_i = 4'($urandom_range(0, 15));
      end
      if_valid_i   = if_pend;
      ls_valid_i   = ls_pend;
      mem_ready_i  = 1'($urandom_range(0, 1));
      mem_rvalid_i = ($urandom_range(0, 2) == 0);
      mem_rdata_i  = $urandom;
      rst_i        = ($urandom_range(0, 99) == 0);
      cycle();
      if (e_if_ready) if_pend = 0;
      if (e_ls_ready) ls_pend = 0;
    end
    idle_inputs();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
